// File: rtl/nmi_apb_pkg.sv
// Shared definitions for the native-memory-interface to APB bridge.
//   apb_state_e : bridge FSM encoding (IDLE, SETUP, ACCESS, RESP).
//   ERR_RDATA   : fill bit for read data returned on a timeout. It is replicated
//                 to the data width, so the result is all-ones.
//   MISS_RDATA  : fill bit for read data returned on a decode miss. It is
//                 replicated to the data width, so the result is all-zeros.
//   clog2       : ceiling log2. clog2(1) = 0 and clog2(2) = 1.
package nmi_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic ERR_RDATA  = 1'b1;
  localparam logic MISS_RDATA = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/nmi_apb_decoder.sv
// Address decoder for the APB slave index field.
// The index is addr[SEL_LSB +: SEL_W]. An index below NUM_SLV selects one slave.
// Any higher index is a decode miss, and then no select bit is set.
//   addr   : byte address from the core.
//   select : one-hot slave select (all zero on a miss).
//   hit    : the index names an existing slave.
// This module is purely combinational.
module nmi_apb_decoder
  import nmi_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] select,
  output logic               hit
);

  localparam int SEL_W = (clog2(NUM_SLV) > 1) ? clog2(NUM_SLV) : 1;

  logic [SEL_W-1:0] idx;
  logic             unused_addr_bits;

  assign idx = addr[SEL_LSB +: SEL_W];

  // Only the index field matters here. Bits outside the field are ignored.
  assign unused_addr_bits = ^addr;

  // NOTE: a default before the loop gives every bit a value on every path,
  // so this block cannot infer a latch.
  always_comb begin
    select = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      select[k] = (32'(idx) == k);
    end
  end

  // An out-of-range index matches no slave. So "no bit set" is the same as a miss.
  assign hit = |select;

endmodule

// File: rtl/nmi2apb_bridge.sv
// Registered bridge from the PicoRV32 native memory interface to a multi-slave
// APB fabric.
//   clk_i, rst_ni                 : clock, async active-low reset.
//   mem_valid_i / mem_ready_o     : core request / one-cycle completion pulse.
//   mem_addr_i, mem_wdata_i,
//   mem_wstrb_i                   : request; wstrb == 0 means a read.
//   mem_rdata_o, mem_err_o        : response, valid while mem_ready_o is 1.
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o, pstrb_o    : APB master outputs (psel_o is one-hot).
//   pready_i, pslverr_i, prdata_i : per-slave APB responses. Slave k uses
//                                   prdata_i[k*DATA_W +: DATA_W].
// Every output is a flop, so no input reaches an output in the same cycle.
// While the bridge is idle, the APB address, data, strobe and direction
// outputs are held at 0.
module nmi2apb_bridge
  import nmi_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      mem_valid_i,
  output logic                      mem_ready_o,
  input  logic [ADDR_W-1:0]         mem_addr_i,
  input  logic [DATA_W-1:0]         mem_wdata_i,
  input  logic [DATA_W/8-1:0]       mem_wstrb_i,
  output logic [DATA_W-1:0]         mem_rdata_o,
  output logic                      mem_err_o,
  output logic [NUM_SLV-1:0]        psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  output logic [DATA_W/8-1:0]       pstrb_o,
  input  logic [NUM_SLV-1:0]        pready_i,
  input  logic [NUM_SLV-1:0]        pslverr_i,
  input  logic [NUM_SLV*DATA_W-1:0] prdata_i
);

  localparam int CNT_W_RAW = clog2(TIMEOUT + 1);
  localparam int CNT_W     = (CNT_W_RAW > 0) ? CNT_W_RAW : 1;

  apb_state_e         state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [NUM_SLV-1:0] dec_select;
  logic               dec_hit;
  logic               sel_ready;
  logic               sel_err;
  logic [DATA_W-1:0]  sel_rdata;
  logic               timeout_hit;

  nmi_apb_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (SEL_LSB)
  ) u_decoder (
    .addr   (mem_addr_i),
    .select (dec_select),
    .hit    (dec_hit)
  );

  // Response mux, keyed by the registered one-hot select. Only the slave we
  // selected can complete or fail the transfer. The other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (psel_o[k]) begin
        sel_ready = sel_ready | pready_i[k];
        sel_err   = sel_err   | pslverr_i[k];
        sel_rdata = sel_rdata | prdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // The counter holds the number of ACCESS cycles already spent waiting.
  // The abort fires in the ACCESS cycle where TIMEOUT waits have already been
  // seen. So the core gets mem_ready_o TIMEOUT+3 cycles after valid.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));

  // NOTE: every state flop uses non-blocking assignment. All flops in this
  // block read the values from before the edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the datapath holding flops are also outputs, so they are reset
      // too. An asserted reset must drive every output to 0 at once.
      state       <= IDLE;
      wait_cnt    <= '0;
      psel_o      <= '0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      mem_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid_i) begin
            if (dec_hit) begin
              psel_o   <= dec_select;
              pwrite_o <= |mem_wstrb_i;
              paddr_o  <= mem_addr_i;
              pwdata_o <= mem_wdata_i;
              pstrb_o  <= mem_wstrb_i;
              wait_cnt <= '0;
              state    <= SETUP;
            end else begin
              // Decode miss: answer the core directly. No APB cycle is started.
              mem_ready_o <= 1'b1;
              mem_rdata_o <= {DATA_W{MISS_RDATA}};
              mem_err_o   <= 1'b1;
              state       <= RESP;
            end
          end
        end

        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end

        ACCESS: begin
          if (sel_ready) begin
            psel_o      <= '0;
            penable_o   <= 1'b0;
            mem_ready_o <= 1'b1;
            mem_rdata_o <= pwrite_o ? '0 : sel_rdata;
            mem_err_o   <= sel_err;
            state       <= RESP;
          end else if (timeout_hit) begin
            psel_o      <= '0;
            penable_o   <= 1'b0;
            mem_ready_o <= 1'b1;
            mem_rdata_o <= {DATA_W{ERR_RDATA}};
            mem_err_o   <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt != {CNT_W{1'b1}}) begin
            // Saturate rather than wrap. This matters when the timeout is disabled.
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          mem_ready_o <= 1'b0;
          mem_rdata_o <= '0;
          mem_err_o   <= 1'b0;
          pwrite_o    <= 1'b0;
          paddr_o     <= '0;
          pwdata_o    <= '0;
          pstrb_o     <= '0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmi2apb_bridge.sv
// Self-checking bench for nmi2apb_bridge. The bridge is configured with
// NUM_SLV=3 and TIMEOUT=8, so both decode misses and timeouts can occur.
// The bench drives the slave side with a small programmable APB slave per
// index. Each slave has a wait-state count, an error flag and read data.
module tb_nmi2apb_bridge;

  localparam int NSLV = 3;
  localparam int TMO  = 8;

  logic        clk_i;
  logic        rst_ni;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] mem_rdata_o;
  logic        mem_err_o;
  logic [2:0]  psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pready_i;
  logic [2:0]  pslverr_i;
  logic [95:0] prdata_i;

  nmi2apb_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .NUM_SLV (NSLV),
    .SEL_LSB (12),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mem_valid_i (mem_valid_i),
    .mem_ready_o (mem_ready_o),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_wstrb_i (mem_wstrb_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_err_o   (mem_err_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .pstrb_o     (pstrb_o),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i),
    .prdata_i    (prdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cycle_no = 0;
  always @(posedge clk_i) cycle_no <= cycle_no + 1;

  // ---------------- programmable slaves ----------------
  int unsigned wait_cfg [NSLV];
  logic        err_cfg  [NSLV];
  logic [31:0] rd_cfg   [NSLV];
  int unsigned acc_cnt  [NSLV];
  logic        noise;

  // A slave that is not in ACCESS drives "noise" on pready and pslverr. The
  // bridge must ignore it.
  always_comb begin
    pready_i  = '0;
    pslverr_i = '0;
    prdata_i  = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (psel_o[k] && penable_o) begin
        pready_i[k]  = (acc_cnt[k] >= wait_cfg[k]);
        pslverr_i[k] = err_cfg[k];
      end else begin
        pready_i[k]  = noise;
        pslverr_i[k] = noise;
      end
      prdata_i[k*32 +: 32] = rd_cfg[k];
    end
  end

  always @(posedge clk_i or negedge rst_ni) begin
    for (int k = 0; k < NSLV; k++) begin
      if (!rst_ni)                         acc_cnt[k] <= 0;
      else if (!(psel_o[k] && penable_o)) acc_cnt[k] <= 0;
      else if (!pready_i[k])               acc_cnt[k] <= acc_cnt[k] + 1;
    end
  end

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_slave(input logic [31:0] addr, input int unsigned w, input logic e,
                           input logic [31:0] rd);
    int idx;
    idx = int'(addr[13:12]);
    if (idx < NSLV) begin
      wait_cfg[idx] = w;
      err_cfg[idx]  = e;
      rd_cfg[idx]   = rd;
    end
  endtask

  // Runs one core transfer. It checks the APB phase behaviour, the latency,
  // the response, and the idle state afterwards. It returns the cycle number
  // at which mem_ready_o was seen.
  task automatic run_xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          output int ready_cycle);
    int   cyc;
    bit   got;
    bit   phase_ok;
    bit   hit;
    logic [2:0] exp_sel;
    hit     = (int'(addr[13:12]) < NSLV);
    exp_sel = hit ? (3'b001 << addr[13:12]) : 3'b000;
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    mem_wstrb_i = wstrb;
    @(posedge clk_i); #1;
    cyc      = 1;
    got      = 0;
    phase_ok = 1;
    while (cyc <= 40) begin
      if (mem_ready_o) begin
        got = 1;
        break;
      end
      if (psel_o !== exp_sel) phase_ok = 0;
      if (penable_o !== (cyc >= 2)) phase_ok = 0;
      if (paddr_o !== addr || pwdata_o !== wdata || pstrb_o !== wstrb ||
          pwrite_o !== (|wstrb)) phase_ok = 0;
      @(posedge clk_i); #1;
      cyc++;
    end
    ready_cycle = cycle_no;
    check({tag, ".latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
    check({tag, ".rdata"}, mem_rdata_o, exp_rdata);
    check({tag, ".err"}, {31'd0, mem_err_o}, {31'd0, exp_err});
    check({tag, ".apb_phase"}, {31'd0, phase_ok}, 32'd1);
    check({tag, ".apb_released"}, {28'd0, psel_o, penable_o}, 32'd0);
    mem_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check({tag, ".idle"}, {27'd0, mem_ready_o, pwrite_o, pstrb_o} | paddr_o | pwdata_o, 32'd0);
  endtask

  // Reference model: the response expected for a request, from the bridge's
  // rules. A miss costs 1 cycle, a normal transfer 3 + waits, a timeout TMO + 3.
  task automatic model(input logic [31:0] addr, input logic [3:0] wstrb, input int w,
                       input logic e, input logic [31:0] rd,
                       output int lat, output logic [31:0] r, output logic err);
    if (int'(addr[13:12]) >= NSLV) begin
      lat = 1; r = 32'd0; err = 1'b1;
    end else if (w > TMO) begin
      lat = TMO + 3; r = 32'hFFFF_FFFF; err = 1'b1;
    end else begin
      lat = 3 + w; r = (wstrb == 4'd0) ? rd : 32'd0; err = e;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_cyc;
    logic        serr;
    logic [31:0] rd;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int r1;
    int r2;
    mem_valid_i = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    mem_wstrb_i = '0;
    noise       = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      wait_cfg[k] = 0;
      err_cfg[k]  = 1'b0;
      rd_cfg[k]   = 32'h1000_0000 + 32'(k);
    end

    //            addr          wdata         wstrb  wait err   rd            lat rdata         err
    vecs[0]  = '{32'h0000_2010, 32'h0,        4'h0,  0,   1'b0, 32'hA5A5_1234, 3,  32'hA5A5_1234, 1'b0};
    vecs[1]  = '{32'h0000_1004, 32'hDEAD_0001, 4'h3, 3,   1'b0, 32'h5555_5555, 6,  32'h0,         1'b0};
    vecs[2]  = '{32'h0000_0008, 32'h0,        4'h0,  0,   1'b1, 32'h1234_5678, 3,  32'h1234_5678, 1'b1};
    vecs[3]  = '{32'h0000_000C, 32'h0,        4'h0,  0,   1'b0, 32'h0BAD_F00D, 3,  32'h0BAD_F00D, 1'b0};
    vecs[4]  = '{32'h0000_1100, 32'h0,        4'h0,  255, 1'b0, 32'h7777_7777, 11, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{32'h0000_3000, 32'h0,        4'h0,  0,   1'b0, 32'h0,         1,  32'h0,         1'b1};
    vecs[6]  = '{32'h0000_3FFC, 32'hCAFE_BABE, 4'hF, 0,   1'b0, 32'h0,         1,  32'h0,         1'b1};
    vecs[7]  = '{32'h0000_2020, 32'h0,        4'h0,  8,   1'b0, 32'h600D_CAFE, 11, 32'h600D_CAFE, 1'b0};
    vecs[8]  = '{32'h0000_2024, 32'h0,        4'h0,  7,   1'b0, 32'h0000_0007, 10, 32'h0000_0007, 1'b0};
    vecs[9]  = '{32'h0000_2028, 32'h0000_00FF, 4'h1, 1,   1'b1, 32'h9999_9999, 4,  32'h0,         1'b1};
    vecs[10] = '{32'h0000_0040, 32'h1111_2222, 4'h8, 9,   1'b0, 32'h3333_3333, 11, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{32'hFFFF_1FFC, 32'h0,        4'h0,  2,   1'b0, 32'hABCD_EF01, 5,  32'hABCD_EF01, 1'b0};

    // Reset state. The request is held during reset and must be ignored.
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    mem_valid_i = 1'b1;
    mem_addr_i  = 32'h0000_2010;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset.outs", {23'd0, psel_o, penable_o, pwrite_o, pstrb_o, mem_ready_o, mem_err_o}
                        | paddr_o | pwdata_o | mem_rdata_o, 32'd0);
    mem_valid_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      set_slave(vecs[i].addr, vecs[i].wait_cyc, vecs[i].serr, vecs[i].rd);
      run_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
               vecs[i].lat, vecs[i].exp_rdata, vecs[i].exp_err, rc);
    end

    // Back-to-back zero-wait transfers complete 4 cycles apart.
    set_slave(32'h0000_0000, 0, 1'b0, 32'h0F0F_0F0F);
    set_slave(32'h0000_1000, 0, 1'b0, 32'hF0F0_F0F0);
    run_xfer("b2b0", 32'h0000_0010, 32'h0, 4'h0, 3, 32'h0F0F_0F0F, 1'b0, r1);
    run_xfer("b2b1", 32'h0000_1010, 32'h0, 4'h0, 3, 32'hF0F0_F0F0, 1'b0, r2);
    check("b2b.spacing", 32'(r2 - r1), 32'd4);

    // Reset pulsed during ACCESS. All outputs must clear without waiting for a clock.
    set_slave(32'h0000_1000, 255, 1'b0, 32'h2468_ACE0);
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem_addr_i  = 32'h0000_1000;
    mem_wdata_i = 32'h1357_9BDF;
    mem_wstrb_i = 4'hF;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mid.in_access", {29'd0, psel_o, penable_o} & 32'h0000_000F, 32'h0000_0005);
    #1 rst_ni = 1'b0;
    #1;
    check("rst_mid.outs", {23'd0, psel_o, penable_o, pwrite_o, pstrb_o, mem_ready_o, mem_err_o}
                          | paddr_o | pwdata_o | mem_rdata_o, 32'd0);
    mem_valid_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    set_slave(32'h0000_1000, 0, 1'b0, 32'h2468_ACE0);
    run_xfer("after_rst", 32'h0000_1008, 32'h0, 4'h0, 3, 32'h2468_ACE0, 1'b0, rc);

    // Randomized traffic, checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          w;
      logic        e;
      int          lat;
      logic [31:0] r;
      logic        err;
      addr        = $urandom;
      addr[13:12] = 2'($urandom_range(0, 3));
      wdata       = $urandom;
      wstrb       = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      w           = $urandom_range(0, 10);
      e           = 1'($urandom_range(0, 1));
      noise       = 1'($urandom_range(0, 1));
      for (int k = 0; k < NSLV; k++) rd_cfg[k] = $urandom;
      set_slave(addr, w, e, $urandom);
      model(addr, wstrb, w, e, rd_cfg[int'(addr[13:12]) % NSLV], lat, r, err);
      run_xfer($sformatf("rnd%0d", i), addr, wdata, wstrb, lat, r, err, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
